// File: rtl/dphy_tx_pkg.sv
// Shared types and default timing for the 4-lane D-PHY TX stub.
package dphy_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LP01,
    ST_LP00,
    ST_HS_ZERO,
    ST_SYNC,
    ST_COLLECT,
    ST_SERIAL,
    ST_TRAIL
  } state_e;

  typedef enum logic [2:0] {
    LANE_HOLD,
    LANE_LP,
    LANE_ZERO,
    LANE_LOAD,
    LANE_SHIFT,
    LANE_TRAIL
  } lane_op_e;

  // LP line states packed as {p, n}
  localparam logic [1:0] LP11 = 2'b11;
  localparam logic [1:0] LP01 = 2'b01;
  localparam logic [1:0] LP00 = 2'b00;

  localparam int unsigned DEF_T_LPX   = 4;
  localparam int unsigned DEF_T_PREP  = 4;
  localparam int unsigned DEF_T_ZERO  = 8;
  localparam int unsigned DEF_T_TRAIL = 4;
  localparam logic [7:0]  SYNC_BYTE   = 8'hB8;

  function automatic logic is_hs_state(input state_e s);
    return s inside {ST_HS_ZERO, ST_SYNC, ST_COLLECT, ST_SERIAL, ST_TRAIL};
  endfunction

endpackage

// File: rtl/dphy_lane_ser.sv
// One data lane: 8-bit load/shift serialiser driving a registered p/n pair.
// In HS the pair is always complementary and holds its last bit on LANE_HOLD.
module dphy_lane_ser
  import dphy_tx_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  lane_op_e   op,
  input  logic [1:0] lp_state,
  input  logic [7:0] load_byte,
  output logic       lane_p,
  output logic       lane_n
);

  logic       p_q, p_d;
  logic       n_q, n_d;
  logic [7:0] sh_q, sh_d;

  always_comb begin
    p_d  = p_q;
    n_d  = n_q;
    sh_d = sh_q;
    case (op)
      LANE_LP: begin
        p_d = lp_state[1];
        n_d = lp_state[0];
      end
      LANE_ZERO: begin
        p_d = 1'b0;
        n_d = 1'b1;
      end
      LANE_LOAD: begin
        p_d  = load_byte[0];
        n_d  = ~load_byte[0];
        sh_d = {1'b0, load_byte[7:1]};
      end
      LANE_SHIFT: begin
        p_d  = sh_q[0];
        n_d  = ~sh_q[0];
        sh_d = {1'b0, sh_q[7:1]};
      end
      LANE_TRAIL: begin
        p_d = ~p_q;
        n_d = p_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      p_q  <= 1'b1;
      n_q  <= 1'b1;
      sh_q <= '0;
    end else begin
      p_q  <= p_d;
      n_q  <= n_d;
      sh_q <= sh_d;
    end
  end

  assign lane_p = p_q;
  assign lane_n = n_q;

endmodule

// File: rtl/dphy_tx_stub_4lane.sv
// Behavioural 4-lane MIPI D-PHY TX stub: AXI-S bytes striped over 4 lanes, one HS bit per clk.
// Optional statistics counters (frame_cnt, byte_cnt) when DPHY_TX_STATS_EN is defined.
module dphy_tx_stub_4lane
  import dphy_tx_pkg::*;
#(
  parameter int unsigned T_LPX   = DEF_T_LPX,
  parameter int unsigned T_PREP  = DEF_T_PREP,
  parameter int unsigned T_ZERO  = DEF_T_ZERO,
  parameter int unsigned T_TRAIL = DEF_T_TRAIL
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        s_axis_tvalid,
  output logic        s_axis_tready,
  input  logic [7:0]  s_axis_tdata,
  input  logic        s_axis_tlast,
  input  logic        s_axis_tuser,
  output logic        mipi_clk_p,
  output logic        mipi_clk_n,
  output logic [3:0]  mipi_data_p,
  output logic [3:0]  mipi_data_n,
`ifdef DPHY_TX_STATS_EN
  output logic [15:0] frame_cnt,
  output logic [31:0] byte_cnt,
`endif
  output state_e      dbg_state
);

  // AXI-S: a byte moves on a rising edge where tvalid && tready; tready is
  // high only in COLLECT and the source may not drop tvalid once raised
  // until that handshake occurs.
  state_e          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [1:0]      idx_q, idx_d;
  logic [3:0][7:0] slot_q, slot_d;
  logic            grp_last_q, grp_last_d;
  logic            tready_q, tready_d;
  logic            clk_p_q, clk_p_d;
  logic            clk_n_q, clk_n_d;

  lane_op_e        lane_op;
  logic [1:0]      lane_lp;
  logic [3:0][7:0] lane_byte;
  logic            hs;

  assign hs = s_axis_tvalid && tready_q;

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    slot_d     = slot_q;
    grp_last_d = grp_last_q;
    lane_op    = LANE_HOLD;
    lane_lp    = LP11;
    lane_byte  = '0;
    case (state_q)
      ST_IDLE: begin
        lane_op = LANE_LP;
        idx_d   = 2'd0;
        if (s_axis_tvalid) begin
          state_d = ST_LP01;
          lane_lp = LP01;
        end
      end
      ST_LP01: begin
        lane_op = LANE_LP;
        lane_lp = LP01;
        if (cnt_q == 4'(T_LPX - 1)) begin
          state_d = ST_LP00;
          lane_lp = LP00;
        end
      end
      ST_LP00: begin
        lane_op = LANE_LP;
        lane_lp = LP00;
        if (cnt_q == 4'(T_PREP - 1)) begin
          state_d = ST_HS_ZERO;
          lane_op = LANE_ZERO;
        end
      end
      ST_HS_ZERO: begin
        lane_op = LANE_ZERO;
        if (cnt_q == 4'(T_ZERO - 1)) begin
          state_d   = ST_SYNC;
          lane_op   = LANE_LOAD;
          lane_byte = {4{SYNC_BYTE}};
        end
      end
      ST_SYNC: begin
        if (cnt_q == 4'd7) begin
          state_d = ST_COLLECT;
          idx_d   = 2'd0;
        end else begin
          lane_op = LANE_SHIFT;
        end
      end
      ST_COLLECT: begin
        if (hs) begin
          slot_d[idx_q] = s_axis_tdata;
          idx_d         = idx_q + 2'd1;
          if (idx_q == 2'd3 || s_axis_tlast) begin
            state_d    = ST_SERIAL;
            lane_op    = LANE_LOAD;
            grp_last_d = s_axis_tlast;
            // Slots beyond the current byte are stale from an earlier group
            for (int i = 0; i < 4; i++) begin
              if (i < int'(idx_q))       lane_byte[i] = slot_q[i];
              else if (i == int'(idx_q)) lane_byte[i] = s_axis_tdata;
              else                       lane_byte[i] = 8'h00;
            end
          end
        end
      end
      ST_SERIAL: begin
        if (cnt_q == 4'd7) begin
          idx_d = 2'd0;
          if (grp_last_q) begin
            state_d = ST_TRAIL;
            lane_op = LANE_TRAIL;
          end else begin
            state_d = ST_COLLECT;
          end
        end else begin
          lane_op = LANE_SHIFT;
        end
      end
      ST_TRAIL: begin
        if (cnt_q == 4'(T_TRAIL - 1)) begin
          state_d = ST_IDLE;
          lane_op = LANE_LP;
        end
      end
      default: begin
        state_d = ST_IDLE;
        lane_op = LANE_LP;
      end
    endcase

    cnt_d    = (state_d != state_q) ? 4'd0 : cnt_q + 4'd1;
    tready_d = (state_d == ST_COLLECT);

    // Clock lane runs HS from the first HS-0 cycle, phase 0 on entry
    if (is_hs_state(state_d)) begin
      clk_p_d = (state_q == ST_LP00) ? 1'b0 : ~clk_p_q;
      clk_n_d = ~clk_p_d;
    end else begin
      clk_p_d = 1'b1;
      clk_n_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= 4'd0;
      idx_q      <= 2'd0;
      slot_q     <= '0;
      grp_last_q <= 1'b0;
      tready_q   <= 1'b0;
      clk_p_q    <= 1'b1;
      clk_n_q    <= 1'b1;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      slot_q     <= slot_d;
      grp_last_q <= grp_last_d;
      tready_q   <= tready_d;
      clk_p_q    <= clk_p_d;
      clk_n_q    <= clk_n_d;
    end
  end

  for (genvar g = 0; g < 4; g++) begin : g_lane
    dphy_lane_ser u_lane (
      .clk       (clk),
      .rst       (rst),
      .op        (lane_op),
      .lp_state  (lane_lp),
      .load_byte (lane_byte[g]),
      .lane_p    (mipi_data_p[g]),
      .lane_n    (mipi_data_n[g])
    );
  end

`ifdef DPHY_TX_STATS_EN
  logic [15:0] frame_cnt_q, frame_cnt_d;
  logic [31:0] byte_cnt_q, byte_cnt_d;

  always_comb begin
    frame_cnt_d = frame_cnt_q;
    byte_cnt_d  = byte_cnt_q;
    if (hs) begin
      byte_cnt_d = byte_cnt_q + 32'd1;
      if (s_axis_tuser) frame_cnt_d = frame_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      frame_cnt_q <= '0;
      byte_cnt_q  <= '0;
    end else begin
      frame_cnt_q <= frame_cnt_d;
      byte_cnt_q  <= byte_cnt_d;
    end
  end

  assign frame_cnt = frame_cnt_q;
  assign byte_cnt  = byte_cnt_q;
`else
  logic unused_tuser;
  assign unused_tuser = s_axis_tuser;
`endif

  assign s_axis_tready = tready_q;
  assign mipi_clk_p    = clk_p_q;
  assign mipi_clk_n    = clk_n_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_dphy_tx_stub_4lane.sv
// Bench for dphy_tx_stub_4lane: directed packet table plus random packets vs a cycle-trace model.
module tb_dphy_tx_stub_4lane;
  import dphy_tx_pkg::*;

  localparam int N_LPX = 4, N_PREP = 4, N_ZERO = 8, N_TRAIL = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        s_axis_tvalid = 1'b0;
  logic        s_axis_tready;
  logic [7:0]  s_axis_tdata = 8'h00;
  logic        s_axis_tlast = 1'b0;
  logic        s_axis_tuser = 1'b0;
  logic        mipi_clk_p, mipi_clk_n;
  logic [3:0]  mipi_data_p, mipi_data_n;
  state_e      dbg_state;
`ifdef DPHY_TX_STATS_EN
  logic [15:0] frame_cnt;
  logic [31:0] byte_cnt;
`endif

  dphy_tx_stub_4lane dut (
    .clk           (clk),
    .rst           (rst),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tlast  (s_axis_tlast),
    .s_axis_tuser  (s_axis_tuser),
    .mipi_clk_p    (mipi_clk_p),
    .mipi_clk_n    (mipi_clk_n),
    .mipi_data_p   (mipi_data_p),
    .mipi_data_n   (mipi_data_n),
`ifdef DPHY_TX_STATS_EN
    .frame_cnt     (frame_cnt),
    .byte_cnt      (byte_cnt),
`endif
    .dbg_state     (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // scoreboard state: {tready, clk_p, clk_n, data_p[3:0], data_n[3:0]} per cycle
  logic [10:0] exp_q[$];
  int          errors = 0;
  int          checks = 0;
  int          fail_prints = 0;
  int          hs_cnt;
  int          last_ser_start;
  logic [31:0] model_grp;
  logic [31:0] obs_grp;
  int          m_bytes = 0;
  int          m_frames = 0;

  logic [7:0]  pkt_data[64];
  int          pkt_gap[64];
  int          pkt_len;

  typedef struct {
    int          n;
    logic [7:0]  first;
    int          gap_at;
    int          gap_len;
    logic [31:0] exp_grp;
  } vec_t;

  vec_t vecs[6];

  task automatic check_val(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  function automatic void push_hs(input logic tr, input logic [3:0] dp);
    logic cp;
    cp = (hs_cnt % 2) == 1;
    exp_q.push_back({tr, cp, ~cp, dp, ~dp});
    hs_cnt++;
  endfunction

  // Expected line trace of one burst, starting with the first LP-01 cycle
  function automatic void build_model();
    logic [7:0] sync_v;
    logic [7:0] slot[4];
    logic [3:0] last, dp;
    sync_v = 8'hB8;
    exp_q.delete();
    hs_cnt = 0;
    repeat (N_LPX)  exp_q.push_back({1'b0, 1'b1, 1'b1, 4'h0, 4'hF});
    repeat (N_PREP) exp_q.push_back({1'b0, 1'b1, 1'b1, 4'h0, 4'h0});
    repeat (N_ZERO) push_hs(1'b0, 4'h0);
    for (int j = 0; j < 8; j++) push_hs(1'b0, {4{sync_v[j]}});
    last = 4'hF;
    for (int base = 0; base < pkt_len; base += 4) begin
      for (int i = 0; i < 4; i++) slot[i] = (base + i < pkt_len) ? pkt_data[base + i] : 8'h00;
      for (int k = base; k < base + 4 && k < pkt_len; k++) begin
        repeat (pkt_gap[k]) push_hs(1'b1, last);
        push_hs(1'b1, last);
      end
      last_ser_start = exp_q.size();
      model_grp = {slot[3], slot[2], slot[1], slot[0]};
      for (int j = 0; j < 8; j++) begin
        for (int i = 0; i < 4; i++) dp[i] = slot[i][j];
        push_hs(1'b0, dp);
        last = dp;
      end
    end
    repeat (N_TRAIL) push_hs(1'b0, ~last);
    exp_q.push_back({1'b0, 1'b1, 1'b1, 4'hF, 4'hF});
  endfunction

  // driver: byte k waits pkt_gap[k] tready-high cycles with tvalid low
  task automatic send_packet();
    int  gaps, budget;
    bit  done;
    budget = 0;
    for (int k = 0; k < pkt_len; k++) begin
      gaps = 0;
      done = 0;
      while (!done && budget < 1000) begin
        if (gaps >= pkt_gap[k]) begin
          s_axis_tvalid = 1'b1;
          s_axis_tdata  = pkt_data[k];
          s_axis_tlast  = (k == pkt_len - 1);
          s_axis_tuser  = (k == 0);
          if (s_axis_tready) begin
            done = 1;
            m_bytes++;
            if (k == 0) m_frames++;
          end
        end else begin
          s_axis_tvalid = 1'b0;
          if (s_axis_tready) gaps++;
        end
        @(negedge clk);
        budget++;
      end
      checks++;
      if (!done) begin
        errors++;
        $display("FAIL handshake_timeout byte %0d: got no handshake want handshake", k);
        break;
      end
    end
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    s_axis_tuser  = 1'b0;
  endtask

  task automatic check_trace(input string name);
    logic [10:0] e, obs;
    int idx;
    idx = 0;
    obs_grp = '0;
    while (exp_q.size() > 0) begin
      @(negedge clk);
      e   = exp_q.pop_front();
      obs = {s_axis_tready, mipi_clk_p, mipi_clk_n, mipi_data_p, mipi_data_n};
      if (idx >= last_ser_start && idx < last_ser_start + 8)
        for (int i = 0; i < 4; i++) obs_grp[i * 8 + (idx - last_ser_start)] = mipi_data_p[i];
      checks++;
      if (obs !== e) begin
        errors++;
        if (fail_prints < 20)
          $display("FAIL %s cycle %0d: got %b want %b (tready,clk_p,clk_n,dp,dn)", name, idx, obs, e);
        fail_prints++;
      end
      idx++;
    end
  endtask

  task automatic run_packet(input string name, input bit use_model, input logic [31:0] grp_want);
    logic [31:0] want;
    build_model();
    want = use_model ? model_grp : grp_want;
    fork
      send_packet();
      check_trace(name);
    join
    check_val({name, " last_group"}, obs_grp, want);
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    m_bytes  = 0;
    m_frames = 0;
  endtask

  initial begin
    vecs[0] = '{4, 8'h01, -1, 0, 32'h04030201};
    vecs[1] = '{6, 8'h10, -1, 0, 32'h00001514};
    vecs[2] = '{8, 8'h20,  2, 5, 32'h27262524};
    vecs[3] = '{1, 8'hFF, -1, 0, 32'h000000FF};
    vecs[4] = '{5, 8'hA0,  4, 3, 32'h000000A4};
    vecs[5] = '{7, 8'h30,  1, 2, 32'h00363534};

    // reset held 3 cycles
    repeat (3) @(negedge clk);
    check_val("reset_lines", {21'd0, s_axis_tready, mipi_clk_p, mipi_clk_n, mipi_data_p, mipi_data_n},
              {21'd0, 1'b0, 1'b1, 1'b1, 4'hF, 4'hF});
    check_val("reset_state", {29'd0, dbg_state}, {29'd0, ST_IDLE});
    rst = 1'b0;

    // directed table
    for (int v = 0; v < 6; v++) begin
      pkt_len = vecs[v].n;
      for (int k = 0; k < pkt_len; k++) begin
        pkt_data[k] = vecs[v].first + 8'(k);
        pkt_gap[k]  = (k == vecs[v].gap_at) ? vecs[v].gap_len : 0;
      end
      run_packet($sformatf("vec%0d", v), 1'b0, vecs[v].exp_grp);
    end

    // random packets
    for (int r = 0; r < 10; r++) begin
      pkt_len = $urandom_range(1, 12);
      for (int k = 0; k < pkt_len; k++) begin
        pkt_data[k] = 8'($urandom_range(0, 255));
        pkt_gap[k]  = (k == 0) ? 0 : $urandom_range(0, 3);
      end
      run_packet($sformatf("rand%0d", r), 1'b1, 32'h0);
    end

    // reset during SERIAL, then a clean restart
    pkt_len = 4;
    for (int k = 0; k < 4; k++) begin
      pkt_data[k] = 8'h41 + 8'(k);
      pkt_gap[k]  = 0;
    end
    send_packet();
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_val("rst_serial_lines", {21'd0, s_axis_tready, mipi_clk_p, mipi_clk_n, mipi_data_p, mipi_data_n},
              {21'd0, 1'b0, 1'b1, 1'b1, 4'hF, 4'hF});
    check_val("rst_serial_state", {29'd0, dbg_state}, {29'd0, ST_IDLE});
    rst = 1'b0;
    m_bytes  = 0;
    m_frames = 0;
    @(negedge clk);
    pkt_len = 6;
    for (int k = 0; k < 6; k++) begin
      pkt_data[k] = 8'h10 + 8'(k);
      pkt_gap[k]  = 0;
    end
    run_packet("after_rst", 1'b0, 32'h00001514);

`ifdef DPHY_TX_STATS_EN
    check_val("stats_frames_run", {16'd0, frame_cnt}, 32'(m_frames));
    check_val("stats_bytes_run", byte_cnt, 32'(m_bytes));
    pulse_reset();
    check_val("stats_frames_reset", {16'd0, frame_cnt}, 32'd0);
    for (int f = 0; f < 2; f++) begin
      pkt_len = 8;
      for (int k = 0; k < 8; k++) begin
        pkt_data[k] = 8'($urandom_range(0, 255));
        pkt_gap[k]  = 0;
      end
      run_packet($sformatf("stats_frame%0d", f), 1'b1, 32'h0);
    end
    check_val("stats_frames", {16'd0, frame_cnt}, 32'd2);
    check_val("stats_bytes", byte_cnt, 32'd16);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
